// File: rtl/avalon_pio_gen.sv
// avalon_pio_gen: parametrised Avalon-MM PIO with per-bit direction, set/clear
// aliases, input synchroniser, edge capture and a maskable level interrupt.

// Per-bit input path: synchroniser chain, one history flop, edge detector.
module avalon_pio_gen_bit #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic sync,
  output logic edge_det
);
  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // shift pin through the synchroniser; prev holds the last synced value
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pin};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_det = sync & ~prev;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_det = ~sync & prev;
    end else begin : g_any
      assign edge_det = sync ^ prev;
    end
  endgenerate
endmodule

module avalon_pio_gen #(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe_port,
  output logic             irq
);
  typedef enum logic {ARMING, ARMED} arm_t;

  // last ARMING cycle index: SYNC_STAGES+1 cycles in total
  localparam logic [2:0] ARM_LAST = 3'(SYNC_STAGES);

  arm_t             state, state_nxt;
  logic [2:0]       cnt, cnt_nxt;
  logic             armed;

  logic [WIDTH-1:0] data_out, dir, mask, edgecap;
  logic [WIDTH-1:0] sync_vec, edge_vec, clr, wd;
  logic [31:0]      rd_mux;
  logic             wr;

  assign wr       = chipselect & ~write_n;
  assign wd       = writedata[WIDTH-1:0];
  assign out_port = data_out;
  assign oe_port  = dir;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      avalon_pio_gen_bit #(
        .SYNC_STAGES(SYNC_STAGES),
        .EDGE_TYPE  (EDGE_TYPE)
      ) u_bit (
        .clk     (clk),
        .reset   (reset),
        .pin     (in_port[i]),
        .sync    (sync_vec[i]),
        .edge_det(edge_vec[i])
      );
    end
  endgenerate

  // arm FSM state and fill counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARMING;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // hold edge detection off until the synchroniser and prev flop have filled
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    armed     = 1'b0;
    case (state)
      ARMING: begin
        if (cnt == ARM_LAST) begin
          state_nxt = ARMED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      ARMED:   armed = 1'b1;
      default: state_nxt = ARMING;
    endcase
  end

  // bus-writable control registers; set/clear aliases modify data_out in place
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= RESET_VALUE;
      dir      <= '0;
      mask     <= '0;
    end else if (wr) begin
      case (address)
        3'd0:    data_out <= wd;
        3'd1:    dir      <= wd;
        3'd2:    mask     <= wd;
        3'd4:    data_out <= data_out | wd;
        3'd5:    data_out <= data_out & ~wd;
        default: ;
      endcase
    end
  end

  assign clr = (wr && address == 3'd3) ? wd : '0;

  // edge capture with write-1-to-clear; a new edge overrides a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      edgecap <= '0;
      irq     <= 1'b0;
    end else begin
      edgecap <= (edgecap & ~clr) | (edge_vec & ~dir & {WIDTH{armed}});
      irq     <= |(edgecap & mask);
    end
  end

  // read mux; unused upper bits and write-only/reserved addresses read 0
  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0:    rd_mux[WIDTH-1:0] = (dir & data_out) | (~dir & sync_vec);
      3'd1:    rd_mux[WIDTH-1:0] = dir;
      3'd2:    rd_mux[WIDTH-1:0] = mask;
      3'd3:    rd_mux[WIDTH-1:0] = edgecap;
      default: rd_mux = '0;
    endcase
  end

  // registered read data, unqualified by chipselect
  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_mux;
  end
endmodule

// File: tb/tb_avalon_pio_gen.sv
// Directed bench for avalon_pio_gen: a rising-edge instance and an any-edge
// instance share the bus; each has its own pins.
module tb_avalon_pio_gen;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect, write_n;
  logic [31:0] writedata;
  logic [31:0] readdata, readdata2;
  logic [7:0]  in_port, out_port, oe_port;
  logic [7:0]  in_port2, out_port2, oe_port2;
  logic        irq, irq2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  avalon_pio_gen #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .RESET_VALUE(8'hA5)) u_dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .oe_port(oe_port), .irq(irq)
  );

  avalon_pio_gen #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2), .RESET_VALUE(8'hA5)) u_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata2),
    .in_port(in_port2), .out_port(out_port2), .oe_port(oe_port2), .irq(irq2)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // advance n clock edges; returns 1ns after the last edge
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    cyc(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // readdata reflects register state before the edge it is captured on
  task automatic rd(input logic [2:0] a);
    address = a;
    cyc(1);
  endtask

  initial begin
    reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = 8'h00; in_port2 = 8'h00;
    cyc(1);
    reset = 1'b0;
    chk("rst_out_port", {24'h0, out_port}, 32'hA5);
    chk("rst_oe_port", {24'h0, oe_port}, 32'h00);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_readdata", readdata, 32'h0);
    rd(3'd1);
    chk("rst_dir_read", readdata, 32'h0);

    // register writes and set/clear aliases
    in_port = 8'h02;
    wr(3'd1, 32'hF0);
    wr(3'd0, 32'h3C);
    wr(3'd4, 32'h01);
    wr(3'd5, 32'h30);
    chk("setclr_out_port", {24'h0, out_port}, 32'h0D);
    chk("dir_oe_port", {24'h0, oe_port}, 32'hF0);
    rd(3'd0);
    chk("data_mixed_read", readdata, 32'h02);
    rd(3'd1);
    chk("dir_read", readdata, 32'hF0);
    rd(3'd4);
    chk("outset_reads0", readdata, 32'h0);
    rd(3'd6);
    chk("reserved_reads0", readdata, 32'h0);
    wr(3'd1, 32'hFFFF_FF0F);
    rd(3'd1);
    chk("dir_upper_ignored", readdata, 32'h0F);
    wr(3'd6, 32'hFFFF_FFFF);
    wr(3'd7, 32'hFFFF_FFFF);
    chk("reserved_write_ignored", {24'h0, out_port}, 32'h0D);

    // reset with a write pending: write dropped; pins high through release
    in_port    = 8'hFF;
    address    = 3'd0;
    writedata  = 32'hFF;
    chipselect = 1'b1;
    write_n    = 1'b0;
    reset      = 1'b1;
    cyc(1);
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    chk("midreset_out_port", {24'h0, out_port}, 32'hA5);
    chk("midreset_oe_port", {24'h0, oe_port}, 32'h00);
    chk("midreset_readdata", readdata, 32'h0);
    cyc(6);
    rd(3'd3);
    chk("arm_suppress", readdata, 32'h0);

    // falling edge is ignored by rising-edge capture
    in_port = 8'hFB;
    cyc(5);
    rd(3'd3);
    chk("fall_ignored", readdata, 32'h0);

    wr(3'd2, 32'h04);
    rd(3'd2);
    chk("mask_read", readdata, 32'h04);

    // bit2 rising edge: capture lands on edge 3, visible on readdata/irq at edge 4
    address = 3'd3;
    in_port = 8'hFF;
    cyc(3);
    chk("edge_e3_readdata", readdata, 32'h0);
    chk("edge_e3_irq", {31'h0, irq}, 32'h0);
    cyc(1);
    chk("edge_e4_readdata", readdata, 32'h04);
    chk("edge_e4_irq", {31'h0, irq}, 32'h1);

    // write-1-to-clear: register clears now, irq one cycle later
    wr(3'd3, 32'h04);
    chk("w1c_irq_lag", {31'h0, irq}, 32'h1);
    cyc(1);
    chk("w1c_irq_drop", {31'h0, irq}, 32'h0);
    chk("w1c_edgecap", readdata, 32'h0);

    // re-capture, then clear in the same cycle as a fresh rising edge
    in_port = 8'hFB;
    cyc(5);
    in_port = 8'hFF;
    cyc(5);
    in_port = 8'hFB;
    cyc(4);
    wr(3'd3, 32'h00);
    cyc(1);
    chk("w0_no_clear", readdata, 32'h04);
    in_port = 8'hFF;
    cyc(2);
    wr(3'd3, 32'h04);
    cyc(1);
    chk("w1c_vs_edge_cap", readdata, 32'h04);
    chk("w1c_vs_edge_irq", {31'h0, irq}, 32'h1);
    cyc(2);
    chk("w1c_vs_edge_irq_hold", {31'h0, irq}, 32'h1);

    // any-edge instance
    in_port2 = 8'h01;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(6);
    rd(3'd3);
    chk("any_arm_suppress", readdata2, 32'h0);
    in_port2 = 8'h00;
    cyc(4);
    chk("any_fall_cap", readdata2, 32'h01);
    wr(3'd3, 32'h01);
    wr(3'd1, 32'h01);
    in_port2 = 8'h01;
    cyc(5);
    in_port2 = 8'h00;
    cyc(5);
    rd(3'd3);
    chk("any_output_no_cap", readdata2, 32'h0);
    rd(3'd0);
    chk("any_data_read", readdata2, 32'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
